// File: rtl/dram_rst_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dram_rst_seq_pkg : state encoding and counter sizing for the sequencer   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package dram_rst_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        WAIT_PLL   = 3'd0,
        POR_WAIT   = 3'd1,
        DLL_RST    = 3'd2,
        DLL_LOCK   = 3'd3,
        STOP_ECLK  = 3'd4,
        DDR_RST    = 3'd5,
        START_ECLK = 3'd6,
        RUN        = 3'd7
    } state_e;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_2ff : two-flop synchroniser, async active-low reset to 0            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/dram_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dram_reset_sequencer : PLL-lock -> POR -> DDRDLL -> ECLK/DDR reset seq.  |
// | Optional DLL-lock timeout: define DRAM_RST_SEQ_TIMEOUT_EN. Revision 1.0  |
// +--------------------------------------------------------------------------+
module dram_reset_sequencer
    import dram_rst_seq_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 100_000_000,
    parameter int POR_DELAY_US     = 600,
    parameter int POR_CYCLES       = CLK_FREQ_HZ / 1_000_000 * POR_DELAY_US,
    parameter int DLL_RST_CYCLES   = 8,
    parameter int ECLK_STOP_CYCLES = 4,
    parameter int LOCK_TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked_i,
    input  logic       dll_locked_i,
    output logic       dll_rst_o,
    output logic       eclk_stop_o,
    output logic       ddr_rst_o,
    output logic       dramsync_rst_o,
    output logic       ready_o,
    output logic [2:0] state_o
`ifdef DRAM_RST_SEQ_TIMEOUT_EN
    ,
    output logic       timeout_o
`endif
);

    localparam int CW = cnt_width(POR_CYCLES, LOCK_TIMEOUT);
    localparam logic [CW-1:0] POR_LOAD  = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] DLL_LOAD  = CW'(DLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] ECLK_LOAD = CW'(ECLK_STOP_CYCLES - 1);
`ifdef DRAM_RST_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LOAD  = CW'(LOCK_TIMEOUT - 1);
`endif

    logic pll_s;
    logic dll_s;

    sync_2ff u_sync_pll (.clk(clk), .rst_n(rst_n), .d_i(pll_locked_i), .q_o(pll_s));
    sync_2ff u_sync_dll (.clk(clk), .rst_n(rst_n), .d_i(dll_locked_i), .q_o(dll_s));

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dll_rst_q, dll_rst_d;
    logic          eclk_stop_q, eclk_stop_d;
    logic          ddr_rst_q, ddr_rst_d;
    logic          dramsync_rst_q, dramsync_rst_d;
    logic          ready_q, ready_d;
`ifdef DRAM_RST_SEQ_TIMEOUT_EN
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
`ifdef DRAM_RST_SEQ_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        // PLL loss overrides everything, including a simultaneous DLL loss
        if (!pll_s) begin
            state_d = WAIT_PLL;
        end else begin
            case (state_q)
                WAIT_PLL: begin
                    state_d = POR_WAIT;
                    cnt_d   = POR_LOAD;
                end
                POR_WAIT: if (cnt_q == '0) begin
                    state_d = DLL_RST;
                    cnt_d   = DLL_LOAD;
                end
                DLL_RST: if (cnt_q == '0) begin
                    state_d = DLL_LOCK;
`ifdef DRAM_RST_SEQ_TIMEOUT_EN
                    cnt_d   = TMO_LOAD;
`endif
                end
                DLL_LOCK: begin
                    if (dll_s) begin
                        state_d = STOP_ECLK;
                        cnt_d   = ECLK_LOAD;
                    end
`ifdef DRAM_RST_SEQ_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        timeout_d = 1'b1;
                        state_d   = DLL_RST;
                        cnt_d     = DLL_LOAD;
                    end
`endif
                end
                STOP_ECLK, DDR_RST, START_ECLK, RUN: begin
                    if (!dll_s) begin
                        state_d = DLL_RST;
                        cnt_d   = DLL_LOAD;
                    end else if (state_q != RUN && cnt_q == '0) begin
                        cnt_d = ECLK_LOAD;
                        if (state_q == STOP_ECLK)
                            state_d = DDR_RST;
                        else if (state_q == DDR_RST)
                            state_d = START_ECLK;
                        else
                            state_d = RUN;
                    end
                end
                default: state_d = WAIT_PLL;
            endcase
        end
    end

    // Outputs decode the next state so they change in the same cycle as state_o
    always_comb begin
        dll_rst_d      = (state_d == WAIT_PLL) || (state_d == POR_WAIT) || (state_d == DLL_RST);
        eclk_stop_d    = (state_d == WAIT_PLL) || (state_d == POR_WAIT) ||
                         (state_d == STOP_ECLK) || (state_d == DDR_RST);
        ddr_rst_d      = (state_d == WAIT_PLL) || (state_d == POR_WAIT) || (state_d == DDR_RST);
        dramsync_rst_d = (state_d != RUN);
        ready_d        = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT_PLL;
            cnt_q          <= '0;
            dll_rst_q      <= 1'b1;
            eclk_stop_q    <= 1'b1;
            ddr_rst_q      <= 1'b1;
            dramsync_rst_q <= 1'b1;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dll_rst_q      <= dll_rst_d;
            eclk_stop_q    <= eclk_stop_d;
            ddr_rst_q      <= ddr_rst_d;
            dramsync_rst_q <= dramsync_rst_d;
            ready_q        <= ready_d;
        end
    end

`ifdef DRAM_RST_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout_q <= 1'b0;
        else        timeout_q <= timeout_d;
    end
    assign timeout_o = timeout_q;
`endif

    assign dll_rst_o      = dll_rst_q;
    assign eclk_stop_o    = eclk_stop_q;
    assign ddr_rst_o      = ddr_rst_q;
    assign dramsync_rst_o = dramsync_rst_q;
    assign ready_o        = ready_q;
    assign state_o        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dram_reset_sequencer : timeline model + directed checks (short POR)   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dram_reset_sequencer;

    localparam int POR    = 200;
    localparam int DLLC   = 8;
    localparam int ECLKC  = 4;
    localparam int LOCKTO = 4096;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       pll_locked_i = 1'b0;
    logic       dll_locked_i = 1'b0;
    logic       dll_rst_o, eclk_stop_o, ddr_rst_o, dramsync_rst_o, ready_o;
    logic [2:0] state_o;
    logic       tmo_act;
`ifdef DRAM_RST_SEQ_TIMEOUT_EN
    logic       timeout_o;
    assign tmo_act = timeout_o;
`else
    assign tmo_act = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    dram_reset_sequencer #(.POR_CYCLES(POR)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pll_locked_i   (pll_locked_i),
        .dll_locked_i   (dll_locked_i),
        .dll_rst_o      (dll_rst_o),
        .eclk_stop_o    (eclk_stop_o),
        .ddr_rst_o      (ddr_rst_o),
        .dramsync_rst_o (dramsync_rst_o),
        .ready_o        (ready_o),
        .state_o        (state_o)
`ifdef DRAM_RST_SEQ_TIMEOUT_EN
        ,
        .timeout_o      (timeout_o)
`endif
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Timeline model: phase 0 idle, 1 POR hold, 2 DLL reset+lock wait, 3 ECLK/DDR steps then run.
    // Position inside a phase is the number of edges since its anchor edge.
    int m_e = 0, m_anchor = 0, m_kind = 0, m_state = 0, m_k = 0;
    bit m_tmo = 1'b0;
    bit p1 = 1'b0, p2 = 1'b0, d1 = 1'b0, d2 = 1'b0, m_ps, m_ds;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_kind = 0; m_state = 0; m_tmo = 1'b0;
            p1 = 1'b0; p2 = 1'b0; d1 = 1'b0; d2 = 1'b0;
        end else begin
            m_e++;
            m_ps = p2; m_ds = d2;
            p2 = p1; p1 = pll_locked_i;
            d2 = d1; d1 = dll_locked_i;
            m_k = m_e - m_anchor;
            if (!m_ps) begin
                m_kind = 0;
            end else begin
                case (m_kind)
                    0: begin m_kind = 1; m_anchor = m_e; end
                    1: if (m_k >= POR) begin m_kind = 2; m_anchor = m_e; end
                    2: if (m_k > DLLC && m_ds) begin m_kind = 3; m_anchor = m_e; end
`ifdef DRAM_RST_SEQ_TIMEOUT_EN
                       else if (m_k >= DLLC + LOCKTO) begin m_tmo = 1'b1; m_anchor = m_e; end
`endif
                    3: if (!m_ds) begin m_kind = 2; m_anchor = m_e; end
                    default: m_kind = 0;
                endcase
            end
            m_k = m_e - m_anchor;
            case (m_kind)
                0:       m_state = 0;
                1:       m_state = 1;
                2:       m_state = (m_k < DLLC) ? 2 : 3;
                default: m_state = (m_k < ECLKC) ? 4 : (m_k < 2*ECLKC) ? 5 : (m_k < 3*ECLKC) ? 6 : 7;
            endcase
        end
    end

    function automatic logic [8:0] expect_vec(input int st, input bit tmo);
        logic [2:0] s;
        s = 3'(st);
        return {s, (st <= 2), (st inside {0, 1, 4, 5}), (st inside {0, 1, 5}),
                (st != 7), (st == 7), tmo};
    endfunction

    logic [8:0] act_v, exp_v;
    initial forever begin
        @(negedge clk);
        act_v = {state_o, dll_rst_o, eclk_stop_o, ddr_rst_o, dramsync_rst_o, ready_o, tmo_act};
        exp_v = expect_vec(m_state, m_tmo);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL model_cycle @%0t: got %b required %b (state,dll,eclk,ddr,dsr,rdy,tmo)",
                     $time, act_v, exp_v);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Runs until dramsync reset drops; counts reset widths once the DLL phase is reached.
    task automatic run_rel(input string name, input int dll_at, input int want,
                           input int want_dll, input int want_ddr);
        int t0, k, nd, nr, nb;
        bit on;
        t0 = cyc; k = 0; nd = 0; nr = 0; nb = 0; on = 1'b0;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (dll_at >= 0 && cyc - t0 == dll_at) dll_locked_i = 1'b1;
            if (state_o >= 3'd2) on = 1'b1;
            if (on) begin
                nd += int'(dll_rst_o);
                nr += int'(ddr_rst_o);
                if (ddr_rst_o && !eclk_stop_o) nb++;
            end
            if (dramsync_rst_o === 1'b0) break;
        end
        check({name, "_bound"}, int'(k < 2000), 1);
        check({name, "_latency"}, cyc - t0, want);
        check({name, "_ready"}, int'(ready_o), 1);
        check({name, "_dll_rst_width"}, nd, want_dll);
        check({name, "_ddr_rst_width"}, nr, want_ddr);
        check({name, "_eclk_during_ddr"}, nb, 0);
    endtask

    initial begin
        int k;
        step(2);
        check("rst_dramsync", int'(dramsync_rst_o), 1);
        check("rst_dll", int'(dll_rst_o), 1);
        check("rst_eclk", int'(eclk_stop_o), 1);
        check("rst_ddr", int'(ddr_rst_o), 1);
        check("rst_ready", int'(ready_o), 0);
        check("rst_state", int'(state_o), 0);
        step(8);
        rst_n = 1'b1;
        step(90);
        check("idle_state", int'(state_o), 0);

        // power-up: PLL lock, DLL lock 50 cycles after DLL_RST exit
        pll_locked_i = 1'b1;
        run_rel("t1", 261, 276, 8, 4);

        // PLL drop for 100 cycles while running
        step(20);
        pll_locked_i = 1'b0;
        step(4);
        check("t3_dramsync_rst", int'(dramsync_rst_o), 1);
        check("t3_state", int'(state_o), 0);
        step(96);
        pll_locked_i = 1'b1;
        run_rel("t3", -1, 224, 8, 4);

        // DLL drop while running: no POR on relock
        step(10);
        dll_locked_i = 1'b0;
        step(4);
        check("t4_state", int'(state_o), 2);
        check("t4_ready", int'(ready_o), 0);
        step(16);
        dll_locked_i = 1'b1;
        run_rel("t4", -1, 15, 0, 4);

        // simultaneous PLL and DLL loss: PLL wins
        step(10);
        pll_locked_i = 1'b0;
        dll_locked_i = 1'b0;
        step(4);
        check("t7_state", int'(state_o), 0);
        step(20);
        pll_locked_i = 1'b1;
        run_rel("t7", 261, 276, 8, 4);

        // rst_n pulse in the middle of POR hold
        step(10);
        pll_locked_i = 1'b0;
        step(10);
        pll_locked_i = 1'b1;
        step(100);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_dramsync", int'(dramsync_rst_o), 1);
        check("t5_async_dll", int'(dll_rst_o), 1);
        check("t5_async_ddr", int'(ddr_rst_o), 1);
        check("t5_async_state", int'(state_o), 0);
        @(negedge clk);
        step(9);
        rst_n = 1'b1;
        run_rel("t5", -1, 224, 8, 4);

`ifdef DRAM_RST_SEQ_TIMEOUT_EN
        step(10);
        dll_locked_i = 1'b0;
        check("t6_tmo_before", int'(timeout_o), 0);
        k = 0;
        while (state_o !== 3'd3 && k < 100) begin @(negedge clk); k++; end
        check("t6_reach_lock", int'(k < 100), 1);
        k = 0;
        while (state_o === 3'd3 && k < 5000) begin @(negedge clk); k++; end
        check("t6_lock_wait", k, LOCKTO);
        check("t6_state", int'(state_o), 2);
        check("t6_tmo_after", int'(timeout_o), 1);
        dll_locked_i = 1'b1;
        run_rel("t6", -1, 21, 7, 4);
        check("t6_tmo_sticky", int'(timeout_o), 1);
`endif

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
